// File: rtl/apostador_pkg.sv
// apostador_pkg
// Shared types and widths for the lottery transmitter (apostador_tx).
//   estado_t : transmitter state machine encoding
//   NUM_W    : width of one ticket number
//   PONTO_W  : width of the p1/p2 scores returned by the lottery core
//   PREMIO_W : width of the premio result
package apostador_pkg;

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      ENVIA   = 3'd1,
      PAUSA   = 3'd2,
      FECHA   = 3'd3,
      FIM     = 3'd4,
      ESPERA  = 3'd5,
      CAPTURA = 3'd6
   } estado_t;

   localparam int NUM_W    = 4;
   localparam int PONTO_W  = 5;
   localparam int PREMIO_W = 2;

endpackage

// File: rtl/apostador_tx_verifica.sv
// verifica_repetidos
// Combinational pairwise compare over a ticket: flags any number that
// appears more than once.
//   bilhete  in  NUM_W*N_NUM  ticket, number i at bilhete[NUM_W*i +: NUM_W]
//   repetido out 1            at least two numbers are equal
module verifica_repetidos
   import apostador_pkg::*;
#(
   parameter int N_NUM = 4
) (
   input  logic [NUM_W*N_NUM-1:0] bilhete,
   output logic                   repetido
);

   always_comb begin
      repetido = 1'b0;
      for (int i = 0; i < N_NUM; i++) begin
         for (int j = i + 1; j < N_NUM; j++) begin
            if (bilhete[i*NUM_W +: NUM_W] == bilhete[j*NUM_W +: NUM_W])
               repetido = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apostador_tx.sv
// apostador_tx
// Transmitter for the lottery game interface. Latches a full ticket on
// start, sends each number as a one-cycle insere strobe, closes the game
// with fim_jogo, waits RESULT_LAT cycles and captures premio/p1/p2.
//
// Optional feature: APOSTADOR_CHECK_EN
//   defined   -> tickets with repeated numbers are rejected (erro=1,
//                immediate pronto, nothing sent, captured result kept)
//   undefined -> every ticket is sent, erro is tied to 0
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   begin a game (only honoured in OCIOSO)
//   bilhete      in   NUM_W*N_NUM ticket, number 0 sent first
//   premio       in   PREMIO_W result from the lottery core
//   p1, p2       in   PONTO_W scores from the lottery core
//   numero       out  number being inserted, 0 when insere is low
//   insere       out  one-cycle strobe per number
//   fim_jogo     out  one-cycle end-of-game strobe
//   ocupado      out  game in progress (cycle 1 through pronto)
//   pronto       out  one-cycle pulse, *_lido valid
//   premio_lido  out  captured premio
//   p1_lido      out  captured p1
//   p2_lido      out  captured p2
//   erro         out  last accepted ticket was rejected
//
// state   | meaning
// --------+--------------------------------------------------------
// OCIOSO  | idle, waiting for start
// ENVIA   | insere strobe for number[idx]
// PAUSA   | GAP idle cycles between inserts
// FECHA   | one idle cycle after the last insert
// FIM     | fim_jogo strobe
// ESPERA  | RESULT_LAT cycles waiting for the core result
// CAPTURA | pronto pulse, captured result valid
module apostador_tx
   import apostador_pkg::*;
#(
   parameter int N_NUM      = 4,
   parameter int GAP        = 1,
   parameter int RESULT_LAT = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NUM_W*N_NUM-1:0] bilhete,
   input  logic [PREMIO_W-1:0]    premio,
   input  logic [PONTO_W-1:0]     p1,
   input  logic [PONTO_W-1:0]     p2,
   output logic [NUM_W-1:0]       numero,
   output logic                   insere,
   output logic                   fim_jogo,
   output logic                   ocupado,
   output logic                   pronto,
   output logic [PREMIO_W-1:0]    premio_lido,
   output logic [PONTO_W-1:0]     p1_lido,
   output logic [PONTO_W-1:0]     p2_lido,
   output logic                   erro
);

   localparam int IDX_W = (N_NUM > 1) ? $clog2(N_NUM) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int LAT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

   localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(N_NUM - 1);
   // Down-counters load N-1 so terminal count 0 marks the last cycle.
   localparam logic [GAP_W-1:0] GAP_CARGA  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
   localparam logic [LAT_W-1:0] LAT_CARGA  = LAT_W'(RESULT_LAT - 1);

   estado_t                estado, estado_prox;
   logic [IDX_W-1:0]       idx, idx_prox;
   logic [GAP_W-1:0]       gap_cnt, gap_prox;
   logic [LAT_W-1:0]       lat_cnt, lat_prox;
   logic [NUM_W*N_NUM-1:0] bilhete_q, bilhete_prox;
   logic                   aceita;
   logic                   amostra;
   logic                   repetido;
   logic [NUM_W-1:0]       numero_prox;

   function automatic logic [NUM_W-1:0] pega_numero(
      input logic [NUM_W*N_NUM-1:0] t,
      input logic [IDX_W-1:0]       i
   );
      pega_numero = '0;
      for (int k = 0; k < N_NUM; k++) begin
         if (i == IDX_W'(k))
            pega_numero = t[k*NUM_W +: NUM_W];
      end
   endfunction

`ifdef APOSTADOR_CHECK_EN
   // Checked on the live input: at the accepting edge it equals what is latched.
   verifica_repetidos #(
      .N_NUM    (N_NUM)
   ) u_verifica (
      .bilhete  (bilhete),
      .repetido (repetido)
   );
`else
   assign repetido = 1'b0;
`endif

   always_comb begin
      estado_prox = estado;
      idx_prox    = idx;
      gap_prox    = gap_cnt;
      lat_prox    = lat_cnt;
      aceita      = 1'b0;
      amostra     = 1'b0;
      case (estado)
         OCIOSO: begin
            if (start) begin
               aceita   = 1'b1;
               idx_prox = '0;
               // A rejected ticket skips straight to the pronto cycle.
               estado_prox = repetido ? CAPTURA : ENVIA;
            end
         end
         ENVIA: begin
            if (idx == IDX_ULTIMO) begin
               estado_prox = FECHA;
            end else if (GAP == 0) begin
               idx_prox = idx + IDX_W'(1);
            end else begin
               estado_prox = PAUSA;
               gap_prox    = GAP_CARGA;
            end
         end
         PAUSA: begin
            if (gap_cnt == '0) begin
               estado_prox = ENVIA;
               idx_prox    = idx + IDX_W'(1);
            end else begin
               gap_prox = gap_cnt - GAP_W'(1);
            end
         end
         FECHA: begin
            estado_prox = FIM;
         end
         FIM: begin
            estado_prox = ESPERA;
            lat_prox    = LAT_CARGA;
         end
         ESPERA: begin
            if (lat_cnt == '0) begin
               amostra     = 1'b1;
               estado_prox = CAPTURA;
            end else begin
               lat_prox = lat_cnt - LAT_W'(1);
            end
         end
         CAPTURA: begin
            estado_prox = OCIOSO;
         end
         default: begin
            estado_prox = OCIOSO;
         end
      endcase
   end

   assign bilhete_prox = aceita ? bilhete : bilhete_q;
   // Outputs are registered from the next-state decode so they line up
   // with the state they belong to.
   assign numero_prox  = (estado_prox == ENVIA) ? pega_numero(bilhete_prox, idx_prox) : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado    <= OCIOSO;
         idx       <= '0;
         gap_cnt   <= '0;
         lat_cnt   <= '0;
         bilhete_q <= '0;
      end else begin
         estado    <= estado_prox;
         idx       <= idx_prox;
         gap_cnt   <= gap_prox;
         lat_cnt   <= lat_prox;
         bilhete_q <= bilhete_prox;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         numero   <= '0;
         insere   <= 1'b0;
         fim_jogo <= 1'b0;
         ocupado  <= 1'b0;
         pronto   <= 1'b0;
      end else begin
         numero   <= numero_prox;
         insere   <= (estado_prox == ENVIA);
         fim_jogo <= (estado_prox == FIM);
         ocupado  <= (estado_prox != OCIOSO);
         pronto   <= (estado_prox == CAPTURA);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         premio_lido <= '0;
         p1_lido     <= '0;
         p2_lido     <= '0;
      end else if (amostra) begin
         premio_lido <= premio;
         p1_lido     <= p1;
         p2_lido     <= p2;
      end
   end

`ifdef APOSTADOR_CHECK_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         erro <= 1'b0;
      else if (aceita)
         erro <= repetido;
   end
`else
   assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_apostador_tx.sv
module tb_apostador_tx;

   typedef struct {
      int         cyc;
      logic [3:0] num;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sel;
   logic [15:0] bilhete;
   logic [1:0]  premio;
   logic [4:0]  p1, p2;

   logic [1:0]  resp_p;
   logic [4:0]  resp_1, resp_2;

   logic        start_a, start_b;
   logic [3:0]  numero_a, numero_b;
   logic        insere_a, insere_b, fim_a, fim_b, ocup_a, ocup_b, pronto_a, pronto_b, erro_a, erro_b;
   logic [1:0]  plido_a, plido_b;
   logic [4:0]  p1lido_a, p1lido_b, p2lido_a, p2lido_b;

   logic [3:0]  w_numero;
   logic        w_insere, w_fim, w_ocupado, w_pronto, w_erro;
   logic [1:0]  w_plido;
   logic [4:0]  w_p1lido, w_p2lido;

   int checks = 0;
   int errors = 0;

   logic [1:0] m_premio [2];
   logic [4:0] m_p1 [2];
   logic [4:0] m_p2 [2];

   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   assign w_numero  = sel ? numero_b : numero_a;
   assign w_insere  = sel ? insere_b : insere_a;
   assign w_fim     = sel ? fim_b    : fim_a;
   assign w_ocupado = sel ? ocup_b   : ocup_a;
   assign w_pronto  = sel ? pronto_b : pronto_a;
   assign w_erro    = sel ? erro_b   : erro_a;
   assign w_plido   = sel ? plido_b  : plido_a;
   assign w_p1lido  = sel ? p1lido_b : p1lido_a;
   assign w_p2lido  = sel ? p2lido_b : p2lido_a;

   apostador_tx #(.N_NUM(4), .GAP(1), .RESULT_LAT(1)) dut_a (
      .clock(clk), .reset(rst), .start(start_a), .bilhete(bilhete),
      .premio(premio), .p1(p1), .p2(p2),
      .numero(numero_a), .insere(insere_a), .fim_jogo(fim_a), .ocupado(ocup_a),
      .pronto(pronto_a), .premio_lido(plido_a), .p1_lido(p1lido_a), .p2_lido(p2lido_a),
      .erro(erro_a)
   );

   apostador_tx #(.N_NUM(4), .GAP(0), .RESULT_LAT(1)) dut_b (
      .clock(clk), .reset(rst), .start(start_b), .bilhete(bilhete),
      .premio(premio), .p1(p1), .p2(p2),
      .numero(numero_b), .insere(insere_b), .fim_jogo(fim_b), .ocupado(ocup_b),
      .pronto(pronto_b), .premio_lido(plido_b), .p1_lido(p1lido_b), .p2_lido(p2lido_b),
      .erro(erro_b)
   );

   // Stub lottery core: presents the result from the fim_jogo cycle on.
   initial begin
      forever begin
         @(negedge clk);
         if (w_fim === 1'b1) begin
            premio = resp_p;
            p1     = resp_1;
            p2     = resp_2;
         end
      end
   end

   function automatic bit tem_repetido(input logic [15:0] t);
      tem_repetido = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (t[i*4 +: 4] == t[j*4 +: 4]) tem_repetido = 1'b1;
   endfunction

   task automatic run_game(input logic [15:0] t, input logic [1:0] rp, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [31:0] pulses, input logic [15:0] t_after);
      ins_t q[$];
      ins_t e;
      int   s, gap, efim, epronto;
      bit   rep, fim_seen, pr_seen;
      s = sel ? 1 : 0;
      gap = sel ? 0 : 1;
      rep = 1'b0;
`ifdef APOSTADOR_CHECK_EN
      rep = tem_repetido(t);
`endif
      if (rep) begin
         efim    = -1;
         epronto = 1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            e.cyc = 1 + i * (gap + 1);
            e.num = t[i*4 +: 4];
            q.push_back(e);
         end
         efim        = 1 + 3 * (gap + 1) + 2;
         epronto     = efim + 2;
         m_premio[s] = rp;
         m_p1[s]     = r1;
         m_p2[s]     = r2;
      end
      resp_p = rp; resp_1 = r1; resp_2 = r2;
      fim_seen = 1'b0;
      pr_seen  = 1'b0;
      @(negedge clk);
      premio = 2'd0; p1 = 5'd0; p2 = 5'd0;
      bilhete = t;
      start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 2) bilhete = t_after;
         checks++;
         if (w_ocupado !== (k <= epronto)) begin
            errors++;
            $display("FAIL ocupado cycle %0d: got %b expected %b", k, w_ocupado, (k <= epronto));
         end
         if (k == 1) begin
            checks++;
            if (w_erro !== rep) begin
               errors++;
               $display("FAIL erro_accept: got %b expected %b", w_erro, rep);
            end
         end
         if (w_insere === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL extra_insere cycle %0d: got numero %0d expected no insere", k, w_numero);
            end else begin
               e = q.pop_front();
               if (e.cyc != k || w_numero !== e.num) begin
                  errors++;
                  $display("FAIL insere: got cycle %0d numero %0d expected cycle %0d numero %0d", k, w_numero, e.cyc, e.num);
               end
            end
         end else begin
            checks++;
            if (w_numero !== 4'd0) begin
               errors++;
               $display("FAIL numero_idle cycle %0d: got %0d expected 0", k, w_numero);
            end
         end
         if (w_fim === 1'b1) begin
            fim_seen = 1'b1;
            checks++;
            if (k != efim) begin
               errors++;
               $display("FAIL fim_jogo: got cycle %0d expected cycle %0d", k, efim);
            end
         end
         if (w_pronto === 1'b1) begin
            pr_seen = 1'b1;
            checks++;
            if (k != epronto || w_plido !== m_premio[s] || w_p1lido !== m_p1[s] ||
                w_p2lido !== m_p2[s] || w_erro !== rep) begin
               errors++;
               $display("FAIL pronto: got cycle %0d premio %0d p1 %0d p2 %0d erro %b expected cycle %0d premio %0d p1 %0d p2 %0d erro %b",
                        k, w_plido, w_p1lido, w_p2lido, w_erro, epronto, m_premio[s], m_p1[s], m_p2[s], rep);
            end
         end
         start = (k < 32) ? pulses[k] : 1'b0;
         if (pr_seen) break;
      end
      checks++;
      if (!pr_seen) begin
         errors++;
         $display("FAIL pronto_timeout: got no pronto expected cycle %0d", epronto);
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_insere: got %0d unsent expected 0", q.size());
      end
      checks++;
      if (fim_seen != (efim > 0)) begin
         errors++;
         $display("FAIL fim_seen: got %b expected %b", fim_seen, (efim > 0));
      end
   endtask

   task automatic check_quiet(input int n, input string nome);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checks++;
         if (w_insere !== 1'b0 || w_fim !== 1'b0 || w_pronto !== 1'b0 || w_ocupado !== 1'b0) begin
            errors++;
            $display("FAIL %s: got insere %b fim %b pronto %b ocupado %b expected all 0",
                     nome, w_insere, w_fim, w_pronto, w_ocupado);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sel = 1'b0; bilhete = 16'h0;
      premio = 2'd0; p1 = 5'd0; p2 = 5'd0;
      for (int s = 0; s < 2; s++) begin
         m_premio[s] = 2'd0; m_p1[s] = 5'd0; m_p2[s] = 5'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_quiet(5, "reset_idle");
      checks++;
      if (w_numero !== 4'd0) begin errors++; $display("FAIL reset_numero: got %0d expected 0", w_numero); end
      checks++;
      if (w_plido !== 2'd0) begin errors++; $display("FAIL reset_premio_lido: got %0d expected 0", w_plido); end
      checks++;
      if (w_p1lido !== 5'd0) begin errors++; $display("FAIL reset_p1_lido: got %0d expected 0", w_p1lido); end
      checks++;
      if (w_p2lido !== 5'd0) begin errors++; $display("FAIL reset_p2_lido: got %0d expected 0", w_p2lido); end
      checks++;
      if (w_erro !== 1'b0) begin errors++; $display("FAIL reset_erro: got %b expected 0", w_erro); end
   endtask

   task automatic test_default();
      sel = 1'b0;
      run_game(16'h8765, 2'd2, 5'd5, 5'd9, 32'h0, 16'h8765);
      check_quiet(3, "default_after");
      checks++;
      if (w_plido !== 2'd2 || w_p1lido !== 5'd5 || w_p2lido !== 5'd9) begin
         errors++;
         $display("FAIL default_hold: got %0d %0d %0d expected 2 5 9", w_plido, w_p1lido, w_p2lido);
      end
   endtask

   task automatic test_gap0();
      sel = 1'b1;
      run_game(16'h0000, 2'd1, 5'd17, 5'd30, 32'h0, 16'h0000);
      check_quiet(3, "gap0_after");
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      // Pulses in cycle 3 (busy) and cycle 11 (pronto) must be ignored;
      // the next game starts in cycle 12. The ticket also changes mid-game.
      run_game(16'h1234, 2'd3, 5'd1, 5'd2, 32'h0000_0808, 16'hFFFF);
      run_game(16'h8765, 2'd2, 5'd5, 5'd9, 32'h0, 16'h0F0F);
      check_quiet(15, "no_queued_start");
   endtask

   task automatic test_reset_mid();
      sel = 1'b1;
      @(negedge clk);
      bilhete = 16'h8765;
      start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (w_insere !== 1'b1 || w_numero !== 4'd8) begin
         errors++;
         $display("FAIL mid_pre_reset: got insere %b numero %0d expected 1 8", w_insere, w_numero);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (w_insere !== 1'b0 || w_numero !== 4'd0 || w_ocupado !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_now: got insere %b numero %0d ocupado %b expected 0 0 0", w_insere, w_numero, w_ocupado);
      end
      checks++;
      if (w_plido !== 2'd0 || w_p1lido !== 5'd0 || w_p2lido !== 5'd0) begin
         errors++;
         $display("FAIL mid_reset_lido: got %0d %0d %0d expected 0 0 0", w_plido, w_p1lido, w_p2lido);
      end
      for (int s = 0; s < 2; s++) begin
         m_premio[s] = 2'd0; m_p1[s] = 5'd0; m_p2[s] = 5'd0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_quiet(20, "mid_reset_quiet");
      sel = 1'b0;
      checks++;
      if (w_plido !== 2'd0 || w_p1lido !== 5'd0 || w_p2lido !== 5'd0) begin
         errors++;
         $display("FAIL mid_reset_lido_a: got %0d %0d %0d expected 0 0 0", w_plido, w_p1lido, w_p2lido);
      end
   endtask

   task automatic test_check();
      sel = 1'b0;
      run_game(16'h1234, 2'd1, 5'd2, 5'd3, 32'h0, 16'h1234);
      run_game(16'h5565, 2'd3, 5'd31, 5'd31, 32'h0, 16'h5565);
      check_quiet(4, "check_after_reject");
      run_game(16'h8765, 2'd2, 5'd5, 5'd9, 32'h0, 16'h8765);
      checks++;
      if (w_erro !== 1'b0) begin
         errors++;
         $display("FAIL erro_cleared: got %b expected 0", w_erro);
      end
   endtask

   initial begin
      resp_p = 2'd0; resp_1 = 5'd0; resp_2 = 5'd0;
      test_reset();
      test_default();
      test_gap0();
      test_back_to_back();
      test_reset_mid();
      test_check();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
